cphy_lane_symbol_aligner: RTL and testbench



---
 rtl/cphy_lane_symbol_aligner.sv | 171 +++++++++++++++++
 tb/tb_cphy_lane_symbol_aligner.sv | 383 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cphy_lane_symbol_aligner.sv
//==============================================================================
// Module   : cphy_lane_symbol_aligner
// Function : Per-lane C-PHY wire-state transition decoder, sync hunt and
//            7-symbol group aligner for the HS receive path.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module cphy_lane_symbol_aligner #(
   parameter int          LANES     = 3,
   parameter logic [20:0] SYNC_WORD = 21'o3444443
) (
   input  logic                  RxSymbolClkHS,
   input  logic                  reset,
   input  logic [LANES-1:0]      DecoderEn,
   input  logic [3*LANES-1:0]    State,
   output logic [3*LANES-1:0]    Sym,
   output logic [LANES-1:0]      SymValid,
   output logic [LANES-1:0]      SymErr,
   output logic [LANES-1:0]      SyncDet,
   output logic [LANES-1:0]      Aligned,
   output logic [21*LANES-1:0]   Group,
   output logic [LANES-1:0]      GroupValid,
   output logic [LANES-1:0]      GroupErr
);

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_SEEK    = 2'd1,
      ST_ALIGNED = 2'd2
   } lane_fsm_t;

   for (genvar i = 0; i < LANES; i++) begin : g_lane
      lane_fsm_t   r_fsm;
      logic [2:0]  r_prev;
      logic        r_has_prev;
      logic [17:0] r_win;
      logic [17:0] r_grp;
      logic [2:0]  r_cnt;
      logic        r_acc;
      logic [2:0]  r_sym;
      logic        r_sym_valid;
      logic        r_sym_err;
      logic        r_sync_det;
      logic        r_aligned;
      logic [20:0] r_group;
      logic        r_group_valid;
      logic        r_group_err;

      logic [2:0]  w_cs;
      logic [2:0]  w_ccw;
      logic [2:0]  w_cw;
      logic        w_illegal;
      logic [2:0]  w_sym;
      logic        w_err;
      logic [20:0] w_win_next;
      logic [20:0] w_grp_next;

      assign w_cs       = State[3*i +: 3];
      assign w_ccw      = {r_prev[1:0], r_prev[2]};
      assign w_cw       = {r_prev[0], r_prev[2:1]};
      assign w_illegal  = (r_prev == 3'b000) || (r_prev == 3'b111) ||
                          (w_cs == 3'b000) || (w_cs == 3'b111) || (w_cs == r_prev);
      assign w_win_next = {r_win, w_sym};
      assign w_grp_next = {r_grp, w_sym};

      // Rules are checked in priority order; anything unmatched is an error.
      always_comb begin
         w_sym = 3'b000;
         w_err = 1'b0;
         if (w_illegal)              w_err = 1'b1;
         else if (w_cs == w_ccw)     w_sym = 3'd0;
         else if (w_cs == ~w_ccw)    w_sym = 3'd1;
         else if (w_cs == w_cw)      w_sym = 3'd2;
         else if (w_cs == ~w_cw)     w_sym = 3'd3;
         else if (w_cs == ~r_prev)   w_sym = 3'd4;
         else                        w_err = 1'b1;
      end

      always_ff @(posedge RxSymbolClkHS or posedge reset) begin
         if (reset) begin
            r_fsm         <= ST_IDLE;
            r_prev        <= 3'b000;
            r_has_prev    <= 1'b0;
            r_win         <= '0;
            r_grp         <= '0;
            r_cnt         <= 3'd0;
            r_acc         <= 1'b0;
            r_sym         <= 3'b000;
            r_sym_valid   <= 1'b0;
            r_sym_err     <= 1'b0;
            r_sync_det    <= 1'b0;
            r_aligned     <= 1'b0;
            r_group       <= '0;
            r_group_valid <= 1'b0;
            r_group_err   <= 1'b0;
         end else if (!DecoderEn[i]) begin
            // Group and GroupErr keep the last delivered word.
            r_fsm         <= ST_IDLE;
            r_prev        <= 3'b000;
            r_has_prev    <= 1'b0;
            r_win         <= '0;
            r_cnt         <= 3'd0;
            r_acc         <= 1'b0;
            r_sym         <= 3'b000;
            r_sym_valid   <= 1'b0;
            r_sym_err     <= 1'b0;
            r_sync_det    <= 1'b0;
            r_aligned     <= 1'b0;
            r_group_valid <= 1'b0;
         end else begin
            r_prev        <= w_cs;
            r_has_prev    <= 1'b1;
            r_sym_valid   <= r_has_prev;
            r_sync_det    <= 1'b0;
            r_group_valid <= 1'b0;
            if (r_has_prev) begin
               r_sym     <= w_sym;
               r_sym_err <= w_err;
            end
            case (r_fsm)
               ST_IDLE: begin
                  r_fsm <= ST_SEEK;
               end
               ST_SEEK: begin
                  if (r_has_prev) begin
                     r_win <= w_win_next[17:0];
                     if ((w_win_next == SYNC_WORD) && !w_err) begin
                        r_fsm      <= ST_ALIGNED;
                        r_aligned  <= 1'b1;
                        r_sync_det <= 1'b1;
                        r_cnt      <= 3'd0;
                        r_acc      <= 1'b0;
                     end
                  end
               end
               ST_ALIGNED: begin
                  if (r_has_prev) begin
                     r_grp <= w_grp_next[17:0];
                     if (r_cnt == 3'd6) begin
                        r_group       <= w_grp_next;
                        r_group_err   <= r_acc | w_err;
                        r_group_valid <= 1'b1;
                        r_cnt         <= 3'd0;
                        r_acc         <= 1'b0;
                     end else begin
                        r_cnt <= r_cnt + 3'd1;
                        r_acc <= r_acc | w_err;
                     end
                  end
               end
               default: begin
                  r_fsm <= ST_IDLE;
               end
            endcase
         end
      end

      assign Sym[3*i +: 3]     = r_sym;
      assign SymValid[i]       = r_sym_valid;
      assign SymErr[i]         = r_sym_err;
      assign SyncDet[i]        = r_sync_det;
      assign Aligned[i]        = r_aligned;
      assign Group[21*i +: 21] = r_group;
      assign GroupValid[i]     = r_group_valid;
      assign GroupErr[i]       = r_group_err;
   end

endmodule

`default_nettype wire

// File: tb/tb_cphy_lane_symbol_aligner.sv
//==============================================================================
// Module   : tb_cphy_lane_symbol_aligner
// Function : Scoreboard bench for cphy_lane_symbol_aligner (3 lanes).
// Revision : 1.0 - initial release
//==============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_cphy_lane_symbol_aligner;
   localparam int          LANES = 3;
   localparam logic [20:0] SYNC  = 21'o3444443;
   localparam int          VW    = 30 * LANES;

   logic                 clk = 1'b0;
   logic                 rst = 1'b1;
   logic [LANES-1:0]     en  = '0;
   logic [3*LANES-1:0]   st  = '0;
   wire  [3*LANES-1:0]   sym;
   wire  [LANES-1:0]     sym_valid, sym_err, sync_det, aligned, group_valid, group_err;
   wire  [21*LANES-1:0]  group;

   always #5 clk = ~clk;

   cphy_lane_symbol_aligner #(.LANES(LANES), .SYNC_WORD(SYNC)) dut (
      .RxSymbolClkHS (clk),
      .reset         (rst),
      .DecoderEn     (en),
      .State         (st),
      .Sym           (sym),
      .SymValid      (sym_valid),
      .SymErr        (sym_err),
      .SyncDet       (sync_det),
      .Aligned       (aligned),
      .Group         (group),
      .GroupValid    (group_valid),
      .GroupErr      (group_err)
   );

   int             n_tests = 0;
   int             n_fail  = 0;
   logic [VW-1:0]  sbq[$];
   logic [2:0]     drv_ps [LANES];

   // Reference model state
   logic [2:0]  m_prev [LANES];
   logic [2:0]  m_sym  [LANES];
   logic        m_has  [LANES];
   logic        m_sv   [LANES];
   logic        m_se   [LANES];
   logic        m_sd   [LANES];
   logic        m_al   [LANES];
   logic        m_gv   [LANES];
   logic        m_ge   [LANES];
   logic        m_acc  [LANES];
   logic [20:0] m_win  [LANES];
   logic [20:0] m_grp  [LANES];
   logic [20:0] m_group[LANES];
   int          m_cnt  [LANES];

   function automatic logic [3:0] ref_decode(input logic [2:0] ps, input logic [2:0] cs);
      logic [2:0] cand [5];
      cand[0] = {ps[1:0], ps[2]};
      cand[1] = ~cand[0];
      cand[2] = {ps[0], ps[2:1]};
      cand[3] = ~cand[2];
      cand[4] = ~ps;
      if (ps == 3'b000 || ps == 3'b111 || cs == 3'b000 || cs == 3'b111 || cs == ps)
         return 4'b1000;
      for (int k = 0; k < 5; k++)
         if (cs == cand[k]) return {1'b0, 3'(k)};
      return 4'b1000;
   endfunction

   function automatic logic [2:0] enc(input logic [2:0] ps, input logic [2:0] s);
      logic [2:0] ccw, cw;
      if (ps == 3'b000 || ps == 3'b111) return 3'b001;
      ccw = {ps[1:0], ps[2]};
      cw  = {ps[0], ps[2:1]};
      case (s)
         3'd0:    return ccw;
         3'd1:    return ~ccw;
         3'd2:    return cw;
         3'd3:    return ~cw;
         default: return ~ps;
      endcase
   endfunction

   function automatic logic [2:0] start_state(input int l);
      case (l % 3)
         0:       return 3'b001;
         1:       return 3'b011;
         default: return 3'b110;
      endcase
   endfunction

   function automatic logic [VW-1:0] model_vec();
      logic [VW-1:0] v;
      for (int l = 0; l < LANES; l++)
         v[30*l +: 30] = {m_sym[l], m_sv[l], m_se[l], m_sd[l], m_al[l], m_gv[l], m_ge[l], m_group[l]};
      return v;
   endfunction

   function automatic logic [VW-1:0] obs();
      logic [VW-1:0] v;
      for (int l = 0; l < LANES; l++)
         v[30*l +: 30] = {sym[3*l +: 3], sym_valid[l], sym_err[l], sync_det[l], aligned[l],
                          group_valid[l], group_err[l], group[21*l +: 21]};
      return v;
   endfunction

   task automatic model_reset();
      for (int l = 0; l < LANES; l++) begin
         m_prev[l] = '0; m_sym[l] = '0; m_has[l] = 0; m_sv[l] = 0; m_se[l] = 0; m_sd[l] = 0;
         m_al[l] = 0; m_gv[l] = 0; m_ge[l] = 0; m_acc[l] = 0; m_win[l] = '0; m_grp[l] = '0;
         m_group[l] = '0; m_cnt[l] = 0; drv_ps[l] = '0;
      end
   endtask

   task automatic model_step(input int l, input logic e, input logic [2:0] cs);
      logic [3:0] d;
      m_sd[l] = 0;
      m_gv[l] = 0;
      if (!e) begin
         m_prev[l] = '0; m_has[l] = 0; m_win[l] = '0; m_cnt[l] = 0; m_al[l] = 0;
         m_sym[l] = '0; m_sv[l] = 0; m_se[l] = 0;
         return;
      end
      m_sv[l] = m_has[l];
      if (m_has[l]) begin
         d = ref_decode(m_prev[l], cs);
         m_sym[l] = d[2:0];
         m_se[l]  = d[3];
         if (!m_al[l]) begin
            m_win[l] = {m_win[l][17:0], d[2:0]};
            if (m_win[l] == SYNC && !d[3]) begin
               m_al[l] = 1; m_sd[l] = 1; m_cnt[l] = 0; m_acc[l] = 0;
            end
         end else begin
            m_grp[l] = {m_grp[l][17:0], d[2:0]};
            m_acc[l] = m_acc[l] | d[3];
            if (m_cnt[l] == 6) begin
               m_group[l] = m_grp[l]; m_ge[l] = m_acc[l]; m_gv[l] = 1;
               m_cnt[l] = 0; m_acc[l] = 0;
            end else begin
               m_cnt[l]++;
            end
         end
      end
      m_prev[l] = cs;
      m_has[l]  = 1;
   endtask

   // One clock: drive at the falling edge, predict, leave time at posedge+1.
   task automatic cycle(input logic [LANES-1:0] e, input logic [3*LANES-1:0] s);
      @(negedge clk);
      en = e;
      st = s;
      for (int l = 0; l < LANES; l++) begin
         model_step(l, e[l], s[3*l +: 3]);
         drv_ps[l] = e[l] ? s[3*l +: 3] : 3'b000;
      end
      sbq.push_back(model_vec());
      @(posedge clk);
      #1;
   endtask

   // Codes: 0..4 symbol, 8 state 000, 9 state 001, 10 per-lane start, 11 all off, 12 repeat state
   task automatic drive_code(input logic [LANES-1:0] e, input int code);
      logic [3*LANES-1:0] s;
      logic [LANES-1:0]   ee;
      for (int l = 0; l < LANES; l++) begin
         case (code)
            8:       s[3*l +: 3] = 3'b000;
            9:       s[3*l +: 3] = 3'b001;
            10:      s[3*l +: 3] = start_state(l);
            12:      s[3*l +: 3] = drv_ps[l];
            default: s[3*l +: 3] = enc(drv_ps[l], 3'(code));
         endcase
      end
      ee = (code == 11) ? {LANES{1'b0}} : e;
      cycle(ee, s);
   endtask

   task automatic test_reset();
      logic [VW-1:0] exp_v;
      rst = 1'b1; en = '0; st = '0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      n_tests++;
      if (obs() !== '0) begin
         n_fail++; $display("FAIL reset_state: got %h exp 0", obs());
      end
      @(negedge clk);
      rst = 1'b0;
      cycle('0, '0);
      exp_v = sbq.pop_front(); n_tests++;
      if (obs() !== exp_v) begin
         n_fail++; $display("FAIL reset_idle: got %h exp %h", obs(), exp_v);
      end
   endtask

   task automatic test_first_symbol();
      int codes[2] = '{9, 0};
      logic [VW-1:0] exp_v;
      foreach (codes[i]) begin
         drive_code(3'b001, codes[i]);
         exp_v = sbq.pop_front(); n_tests++;
         if (obs() !== exp_v) begin
            n_fail++; $display("FAIL first_symbol step%0d: got %h exp %h", i, obs(), exp_v);
         end
         n_tests++;
         if (i == 0 && sym_valid[0] !== 1'b0) begin
            n_fail++; $display("FAIL first_novalid: got %b exp 0", sym_valid[0]);
         end else if (i == 1 && {sym[2:0], sym_valid[0], sym_err[0]} !== 5'b00010) begin
            n_fail++; $display("FAIL first_sym: got %b exp 00010", {sym[2:0], sym_valid[0], sym_err[0]});
         end
      end
   endtask

   task automatic test_decode();
      int codes[8] = '{11, 9, 1, 3, 2, 0, 4, 12};
      logic [VW-1:0] exp_v;
      logic [3:0] want;
      foreach (codes[i]) begin
         drive_code(3'b001, codes[i]);
         exp_v = sbq.pop_front(); n_tests++;
         if (obs() !== exp_v) begin
            n_fail++; $display("FAIL decode step%0d: got %h exp %h", i, obs(), exp_v);
         end
         if (i == 2 || i == 4 || i == 6 || i == 7) begin
            want = (i == 2) ? 4'b0001 : (i == 4) ? 4'b0010 : (i == 6) ? 4'b0100 : 4'b1000;
            n_tests++;
            if ({sym_err[0], sym[2:0]} !== want || sym_valid[0] !== 1'b1) begin
               n_fail++; $display("FAIL decode_sym step%0d: got err/sym %b valid %b exp %b", i, {sym_err[0], sym[2:0]}, sym_valid[0], want);
            end
         end
      end
   endtask

   task automatic test_sync();
      int codes[12] = '{11, 10, 3, 3, 3, 3, 4, 4, 4, 4, 4, 3};
      logic [VW-1:0] exp_v;
      int n_sd = 0;
      int sd_step = -1;
      foreach (codes[i]) begin
         drive_code('1, codes[i]);
         exp_v = sbq.pop_front(); n_tests++;
         if (obs() !== exp_v) begin
            n_fail++; $display("FAIL sync step%0d: got %h exp %h", i, obs(), exp_v);
         end
         if (sync_det[0]) begin n_sd++; sd_step = i; end
      end
      n_tests++;
      if (n_sd != 1 || sd_step != 11) begin
         n_fail++; $display("FAIL sync_pulse: got %0d pulses at step %0d exp 1 at step 11", n_sd, sd_step);
      end
      n_tests++;
      if (aligned !== '1) begin
         n_fail++; $display("FAIL sync_aligned: got %b exp 111", aligned);
      end
   endtask

   task automatic test_groups();
      int codes[14] = '{0, 1, 2, 3, 4, 0, 1, 1, 2, 8, 9, 3, 4, 0};
      logic [VW-1:0] exp_v;
      int n_gv = 0;
      foreach (codes[i]) begin
         drive_code('1, codes[i]);
         exp_v = sbq.pop_front(); n_tests++;
         if (obs() !== exp_v) begin
            n_fail++; $display("FAIL groups step%0d: got %h exp %h", i, obs(), exp_v);
         end
         if (group_valid[0]) n_gv++;
         if (i == 6) begin
            n_tests++;
            if (group_valid[0] !== 1'b1 || group[20:0] !== 21'o0123401 || group_err[0] !== 1'b0) begin
               n_fail++; $display("FAIL group_clean: got gv %b grp %o err %b exp 1 0123401 0", group_valid[0], group[20:0], group_err[0]);
            end
         end
         if (i == 13) begin
            n_tests++;
            if (group_valid[0] !== 1'b1 || group[20:0] !== 21'o1200340 || group_err[0] !== 1'b1) begin
               n_fail++; $display("FAIL group_err: got gv %b grp %o err %b exp 1 1200340 1", group_valid[0], group[20:0], group_err[0]);
            end
         end
      end
      n_tests++;
      if (n_gv != 2) begin
         n_fail++; $display("FAIL group_count: got %0d exp 2", n_gv);
      end
   endtask

   task automatic test_lane_drop();
      int codes[7] = '{2, 3, 4, 0, 1, 2, 3};
      logic [VW-1:0] exp_v;
      int n_gv0 = 0;
      int n_gv1 = 0;
      foreach (codes[i]) begin
         drive_code((i < 4) ? 3'b111 : 3'b101, codes[i]);
         exp_v = sbq.pop_front(); n_tests++;
         if (obs() !== exp_v) begin
            n_fail++; $display("FAIL lane_drop step%0d: got %h exp %h", i, obs(), exp_v);
         end
         if (group_valid[0]) n_gv0++;
         if (group_valid[1]) n_gv1++;
      end
      n_tests++;
      if (n_gv0 != 1 || group[20:0] !== 21'o2340123) begin
         n_fail++; $display("FAIL drop_lane0: got %0d groups grp %o exp 1 2340123", n_gv0, group[20:0]);
      end
      n_tests++;
      if (n_gv1 != 0 || aligned[1] !== 1'b0 || group[41:21] !== 21'o1200340 || group_err[1] !== 1'b1) begin
         n_fail++; $display("FAIL drop_lane1: got gv %0d al %b grp %o err %b exp 0 0 1200340 1", n_gv1, aligned[1], group[41:21], group_err[1]);
      end
   endtask

   task automatic test_reset_mid();
      int pre[3]    = '{4, 0, 1};
      int hunt[14]  = '{0, 1, 2, 3, 4, 0, 1, 2, 3, 4, 0, 1, 2, 3};
      int lock[14]  = '{3, 4, 4, 4, 4, 4, 3, 1, 1, 1, 1, 1, 1, 1};
      logic [VW-1:0] exp_v;
      int n_gv = 0;
      foreach (pre[i]) begin
         drive_code('1, pre[i]);
         exp_v = sbq.pop_front(); n_tests++;
         if (obs() !== exp_v) begin
            n_fail++; $display("FAIL reset_mid pre%0d: got %h exp %h", i, obs(), exp_v);
         end
      end
      @(negedge clk);
      en = '0;
      #2;
      rst = 1'b1;
      model_reset();
      #1;
      n_tests++;
      if (obs() !== '0) begin
         n_fail++; $display("FAIL reset_async: got %h exp 0", obs());
      end
      @(negedge clk);
      rst = 1'b0;
      foreach (hunt[i]) begin
         drive_code('1, hunt[i]);
         exp_v = sbq.pop_front(); n_tests++;
         if (obs() !== exp_v) begin
            n_fail++; $display("FAIL reset_hunt step%0d: got %h exp %h", i, obs(), exp_v);
         end
         if (group_valid !== '0) n_gv++;
      end
      n_tests++;
      if (n_gv != 0 || aligned !== '0) begin
         n_fail++; $display("FAIL reset_nosync: got %0d groups aligned %b exp 0 000", n_gv, aligned);
      end
      foreach (lock[i]) begin
         drive_code('1, lock[i]);
         exp_v = sbq.pop_front(); n_tests++;
         if (obs() !== exp_v) begin
            n_fail++; $display("FAIL reset_relock step%0d: got %h exp %h", i, obs(), exp_v);
         end
         if (group_valid[0]) n_gv++;
      end
      n_tests++;
      if (n_gv != 1 || group[20:0] !== 21'o1111111) begin
         n_fail++; $display("FAIL reset_relock_group: got %0d groups grp %o exp 1 1111111", n_gv, group[20:0]);
      end
   endtask

   initial begin
      test_reset();
      test_first_symbol();
      test_decode();
      test_sync();
      test_groups();
      test_lane_drop();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
